// File: rtl/statki_pkg.sv
// Shared constants, fleet table and FSM state type for the ship placement slice.
package statki_pkg;
  localparam int N_CELLS = 10;
  localparam int FLEET_N = 10;
  localparam int ADDR_W  = 7;

  localparam logic [2:0] FLEET_LEN [0:FLEET_N-1] = '{
    3'd4, 3'd3, 3'd3, 3'd2, 3'd2, 3'd2, 3'd1, 3'd1, 3'd1, 3'd1
  };

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WAIT,
    S_BOUND,
    S_CHECK,
    S_WRITE
  } place_state_t;

  // row*10+col built from shifts so no multiplier is needed.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [3:0] row,
                                                  input logic [3:0] col);
    logic [ADDR_W-1:0] r;
    r = {3'b000, row};
    return (r << 3) + (r << 1) + {3'b000, col};
  endfunction
endpackage

// File: rtl/ship_place_ctl_if.sv
// Board RAM port: one read address with 1-cycle read data, one write port.
interface ship_place_ctl_if;
  import statki_pkg::*;

  logic [ADDR_W-1:0] rd_addr;
  logic              rd_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_data;

  modport master (output rd_addr, wr_en, wr_addr, wr_data, input rd_data);
  modport slave  (input rd_addr, wr_en, wr_addr, wr_data, output rd_data);
endinterface

// File: rtl/mouse_to_cell.sv
// Registered pixel-to-cell mapping; row/col forced to 0 when the mouse is off the board.
module mouse_to_cell
  import statki_pkg::*;
#(
  parameter int GRID_X0   = 100,
  parameter int GRID_Y0   = 100,
  parameter int CELL_LOG2 = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  output logic [3:0]  cursor_row,
  output logic [3:0]  cursor_col,
  output logic        cursor_valid
);
  logic [11:0] dx, dy, cx, cy;
  logic        in_board;

  assign dx = mouse_xpos - 12'(GRID_X0);
  assign dy = mouse_ypos - 12'(GRID_Y0);
  assign cx = dx >> CELL_LOG2;
  assign cy = dy >> CELL_LOG2;
  assign in_board = (mouse_xpos >= 12'(GRID_X0)) && (mouse_ypos >= 12'(GRID_Y0)) &&
                    (cx < 12'(N_CELLS)) && (cy < 12'(N_CELLS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cursor_row   <= 4'd0;
      cursor_col   <= 4'd0;
      cursor_valid <= 1'b0;
    end else begin
      cursor_row   <= in_board ? cy[3:0] : 4'd0;
      cursor_col   <= in_board ? cx[3:0] : 4'd0;
      cursor_valid <= in_board;
    end
  end
endmodule

// File: rtl/ship_place_ctl.sv
// Fleet placement sequencer: clears the board, then validates and writes ten ships
// chosen by mouse clicks, checking bounds and overlap against board RAM.
module ship_place_ctl
  import statki_pkg::*;
#(
  parameter int GRID_X0   = 100,
  parameter int GRID_Y0   = 100,
  parameter int CELL_LOG2 = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [11:0]             mouse_xpos,
  input  logic [11:0]             mouse_ypos,
  input  logic                    mouse_left,
  input  logic                    mouse_right,
  input  logic                    start,
  ship_place_ctl_if.master        ram,
  output logic [3:0]              cursor_row,
  output logic [3:0]              cursor_col,
  output logic                    cursor_valid,
  output logic                    orient,
  output logic [2:0]              ship_len,
  output logic [3:0]              ship_idx,
  output logic                    placing,
  output logic                    done,
  output logic                    err
);
  place_state_t      state, state_nx;
  logic              left_prev, right_prev, left_edge, right_edge;
  logic [3:0]        ship_idx_nx, lat_row, lat_row_nx, lat_col, lat_col_nx;
  logic              orient_nx, placing_nx, done_nx, lat_orient, lat_orient_nx, orient_tog;
  logic [6:0]        clr_cnt, clr_cnt_nx;
  logic [2:0]        step, step_nx, len;
  logic [3:0]        step_row, step_col;
  logic [ADDR_W-1:0] step_addr;
  logic [4:0]        end_pos;

  mouse_to_cell #(.GRID_X0(GRID_X0), .GRID_Y0(GRID_Y0), .CELL_LOG2(CELL_LOG2)) u_cell (
    .clk(clk), .rst(rst), .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos),
    .cursor_row(cursor_row), .cursor_col(cursor_col), .cursor_valid(cursor_valid)
  );

  assign left_edge  = mouse_left & ~left_prev;
  assign right_edge = mouse_right & ~right_prev;
  assign len        = FLEET_LEN[ship_idx];
  assign ship_len   = placing ? len : 3'd0;
  assign step_row   = lat_row + (lat_orient ? {1'b0, step} : 4'd0);
  assign step_col   = lat_col + (lat_orient ? 4'd0 : {1'b0, step});
  assign step_addr  = cell_addr(step_row, step_col);
  assign end_pos    = (lat_orient ? {1'b0, lat_row} : {1'b0, lat_col}) + {2'b00, len} - 5'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      left_prev  <= 1'b0;
      right_prev <= 1'b0;
      ship_idx   <= 4'd0;
      orient     <= 1'b0;
      placing    <= 1'b0;
      done       <= 1'b0;
      clr_cnt    <= 7'd0;
      step       <= 3'd0;
      lat_row    <= 4'd0;
      lat_col    <= 4'd0;
      lat_orient <= 1'b0;
    end else begin
      state      <= state_nx;
      left_prev  <= mouse_left;
      right_prev <= mouse_right;
      ship_idx   <= ship_idx_nx;
      orient     <= orient_nx;
      placing    <= placing_nx;
      done       <= done_nx;
      clr_cnt    <= clr_cnt_nx;
      step       <= step_nx;
      lat_row    <= lat_row_nx;
      lat_col    <= lat_col_nx;
      lat_orient <= lat_orient_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    ship_idx_nx   = ship_idx;
    orient_nx     = orient;
    placing_nx    = placing;
    done_nx       = done;
    clr_cnt_nx    = clr_cnt;
    step_nx       = step;
    lat_row_nx    = lat_row;
    lat_col_nx    = lat_col;
    lat_orient_nx = lat_orient;
    orient_tog    = orient ^ right_edge;
    err           = 1'b0;
    ram.rd_addr   = '0;
    ram.wr_en     = 1'b0;
    ram.wr_addr   = '0;
    ram.wr_data   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          ship_idx_nx = 4'd0;
          orient_nx   = 1'b0;
          done_nx     = 1'b0;
          clr_cnt_nx  = 7'd0;
          state_nx    = S_CLEAR;
        end
      end
      S_CLEAR: begin
        ram.wr_en   = 1'b1;
        ram.wr_addr = clr_cnt;
        clr_cnt_nx  = clr_cnt + 7'd1;
        if (clr_cnt == 7'(N_CELLS * N_CELLS - 1)) begin
          placing_nx = 1'b1;
          state_nx   = S_WAIT;
        end
      end
      S_WAIT: begin
        // A simultaneous right edge toggles before the left edge latches orientation.
        orient_nx = orient_tog;
        if (left_edge && cursor_valid) begin
          lat_row_nx    = cursor_row;
          lat_col_nx    = cursor_col;
          lat_orient_nx = orient_tog;
          state_nx      = S_BOUND;
        end
      end
      S_BOUND: begin
        step_nx = 3'd0;
        if (end_pos >= 5'(N_CELLS)) begin
          err      = 1'b1;
          state_nx = S_WAIT;
        end else begin
          state_nx = S_CHECK;
        end
      end
      S_CHECK: begin
        // Read of cell k is issued at step k; its data is judged at step k+1.
        if (step < len) ram.rd_addr = step_addr;
        if (step != 3'd0 && ram.rd_data) begin
          err      = 1'b1;
          state_nx = S_WAIT;
        end else if (step == len) begin
          step_nx  = 3'd0;
          state_nx = S_WRITE;
        end else begin
          step_nx = step + 3'd1;
        end
      end
      S_WRITE: begin
        ram.wr_en   = 1'b1;
        ram.wr_addr = step_addr;
        ram.wr_data = 1'b1;
        step_nx     = step + 3'd1;
        if (step == len - 3'd1) begin
          if (ship_idx == 4'(FLEET_N - 1)) begin
            placing_nx = 1'b0;
            done_nx    = 1'b1;
            state_nx   = S_IDLE;
          end else begin
            ship_idx_nx = ship_idx + 4'd1;
            state_nx    = S_WAIT;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end
endmodule

// File: doc/ship_place_ctl.md
Name: ship_place_ctl

Overview:
Sequences player fleet placement on the 10x10 own board.
- Converts mouse coordinates to a grid cell and edge-detects mouse_left / mouse_right.
- Validates each requested ship position against board bounds and occupancy, then writes accepted ships into board RAM.
- Sits between the mouse controller and board memory; its cursor/orientation outputs feed the placement-preview draw block.

Parameters:
GRID_X0, 100, pixel x of board's left edge
GRID_Y0, 100, pixel y of board's top edge
CELL_LOG2, 5, log2 of cell size in pixels (32 px)
N_CELLS, 10, cells per board side

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
mouse_xpos  in  12  mouse x, pixels
mouse_ypos  in  12  mouse y, pixels
mouse_left  in  1  left button level; rising edge = place
mouse_right  in  1  right button level; rising edge = toggle orientation
start  in  1  one-cycle pulse; begin placement of a fresh fleet
rd_addr  out  7  board RAM read address, row*10+col
rd_data  in  1  board RAM read data (1 = occupied); valid 1 cycle after rd_addr
wr_en  out  1  board RAM write strobe
wr_addr  out  7  board RAM write address
wr_data  out  1  board RAM write data (always 1 when wr_en)
cursor_row  out  4  grid row under mouse
cursor_col  out  4  grid column under mouse
cursor_valid  out  1  mouse inside board
orient  out  1  0 = horizontal (extends +col), 1 = vertical (extends +row)
ship_len  out  3  length of ship currently being placed
ship_idx  out  4  index of ship being placed, 0..9
placing  out  1  high while awaiting placements
done  out  1  high once all 10 ships are placed
err  out  1  one-cycle pulse on rejected placement

Behaviour:
- Reset values: all outputs 0; state IDLE; edge-detect registers 0.
- Fleet order, fixed by ship_idx: lengths 4,3,3,2,2,2,1,1,1,1 (20 cells total).
- Cursor mapping, registered with 1-cycle latency:
  - dx = mouse_xpos - GRID_X0 and dy = mouse_ypos - GRID_Y0, 12-bit unsigned.
  - col = dx >> CELL_LOG2, row = dy >> CELL_LOG2.
  - cursor_valid = (mouse_xpos >= GRID_X0) && (mouse_ypos >= GRID_Y0) && col < N_CELLS && row < N_CELLS.
  - When invalid: row and col are forced to 0.
- Edge detect: registered previous button levels; an edge is current & ~previous.
- State machine:
  - IDLE: done/placing as last set. start -> clear ship_idx, orient=0, done=0 -> CLEAR.
  - CLEAR: writes 0 to addresses 0..99, one per cycle; wr_data = 0 only here. Then -> WAIT.
  - WAIT: placing=1.
    - Right edge toggles orient.
    - Left edge with cursor_valid: latch row, col, orient -> BOUND.
    - Left edge with cursor invalid: ignored.
    - Simultaneous left and right edges: the toggle applies first and the latched orient is the toggled value.
  - BOUND, 1 cycle: end = start + len - 1 along orient; if end >= N_CELLS -> err pulse, -> WAIT, no RAM access.
  - CHECK: pipelined reads of the ship's len cells, one per cycle; rd_data is sampled the following cycle.
    - Any 1 -> err pulse, -> WAIT (abandon remaining reads).
    - All 0 -> WRITE.
    - Duration: len+1 cycles.
  - WRITE: len cycles, wr_en=1, wr_data=1, cell addresses in ascending order. Then ship_idx++.
    - If ship_idx was 9: placing=0, done=1 -> IDLE.
    - Otherwise: -> WAIT.
- Button edges arriving outside WAIT are discarded; edge registers are still updated.
- start pulses outside IDLE are ignored.
- Address arithmetic: 7-bit row*10+col computed as (row<<3)+(row<<1)+col.
- Asynchronous reset mid-WRITE: the partially written ship stays in RAM; the next start's CLEAR erases it.
- No adjacency (touching) rule; only bounds and overlap are checked.

Decomposition:
- Package statki_pkg: N_CELLS, fleet length table FLEET_LEN[0:9], state enum place_state_t, ADDR_W=7.
- Sub-module mouse_to_cell: registered pixel-to-cell mapping plus cursor_valid.
- Edge detection and FSM stay in ship_place_ctl.

Test Plan:
1. Reset then start -> 100 wr_en cycles with wr_data=0 for addresses 0..99; then placing=1, ship_idx=0, ship_len=4, done=0.
2. Mouse (100,100), left click, orient 0 -> no err; wr_addr 0,1,2,3 with wr_data=1; ship_idx=1, ship_len=3.
3. Right click, then click at (100,100+8*32) with ship_len 3 vertical -> end row 10 -> err pulse for 1 cycle; no wr_en; ship_idx unchanged.
4. Click at (100+2*32,100) horizontal len 3 with RAM cells 2,3 occupied -> err pulse; no writes; FSM back in WAIT.
5. Mouse (50,50), left click -> cursor_valid=0; no rd/wr activity; no err.
6. Place all 10 ships on non-overlapping rows -> exactly 20 writes with wr_data=1; done=1, placing=0; a further left click produces no writes.
